// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle control sequencer for the single-port RV32I core
module mc_ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_sel,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_BAD
  } cls_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             state_q;
  cls_t               cls_q;
  cls_t               cls_dec;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q;
  logic               bus_err_q;
  logic               waiting;
  logic               timeout_hit;
  logic               retire_ev;
  logic [2:0]         funct3;
  logic               unused_instr;

  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify the opcode held in the instruction register
  always_comb begin
    cls_dec = C_BAD;
    case (instr[6:0])
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b1101111: cls_dec = C_JAL;
      7'b0110111: cls_dec = C_LUI;
      default:    cls_dec = C_BAD;
    endcase
  end

  function automatic logic [2:0] imm_of(cls_t c);
    case (c)
      C_I, C_LOAD: return 3'd1;
      C_STORE:     return 3'd2;
      C_BRANCH:    return 3'd3;
      C_LUI:       return 3'd4;
      C_JAL:       return 3'd5;
      default:     return 3'd0;
    endcase
  endfunction

  // A memory wait that reaches the limit without a handshake becomes a bus error
  assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_q == WAIT_LAST);
  assign retire_ev   = ((state_q == S_EXEC) && (cls_q == C_BRANCH)) ||
                       ((state_q == S_MEM) && (cls_q == C_STORE) && mem_ready) ||
                       (state_q == S_WB);

  // State sequencing, class latch, wait counter, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (retire_ev) retired_q <= retired_q + 1'b1;
      if (waiting && !timeout_hit) wait_q <= wait_q + 1'b1;
      else                         wait_q <= '0;
      case (state_q)
        S_FETCH: begin
          if (timeout_hit) begin
            state_q   <= S_TRAP;
            bus_err_q <= 1'b1;
          end else if (mem_ready) begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          cls_q <= cls_dec;
          if (cls_dec == C_BAD) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_LOAD, C_STORE: state_q <= S_MEM;
            C_BRANCH:        state_q <= S_FETCH;
            default:         state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (timeout_hit) begin
            state_q   <= S_TRAP;
            bus_err_q <= 1'b1;
          end else if (mem_ready) begin
            state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Control outputs decoded from state and class; all held low during reset
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    imm_sel   = 3'd0;
    alu_src_b = 1'b0;
    alu_op    = 4'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_DECODE: imm_sel = imm_of(cls_dec);
        S_EXEC, S_WB: begin
          imm_sel = imm_of(cls_q);
          case (cls_q)
            C_R: alu_op = {instr[30], funct3};
            C_I: begin
              alu_src_b = 1'b1;
              alu_op    = {instr[30] & (funct3 == 3'b101), funct3};
            end
            C_LOAD, C_STORE: alu_src_b = 1'b1;
            C_BRANCH: begin
              alu_op = 4'b1000;
              pc_we  = 1'b1;
              pc_sel = br_taken ? 2'd1 : 2'd0;
            end
            default: ;
          endcase
          if (state_q == S_WB) begin
            rf_we = 1'b1;
            pc_we = 1'b1;
            case (cls_q)
              C_LOAD:  wb_sel = 2'd1;
              C_JAL: begin
                wb_sel = 2'd2;
                pc_sel = 2'd1;
              end
              C_LUI:   wb_sel = 2'd3;
              default: wb_sel = 2'd0;
            endcase
          end
        end
        S_MEM: begin
          imm_sel   = imm_of(cls_q);
          alu_src_b = 1'b1;
          mem_req   = 1'b1;
          mem_we    = (cls_q == C_STORE);
          if ((cls_q == C_STORE) && mem_ready) pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h0000A103;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] SW  = 32'h0020A023;
  localparam logic [31:0] BAD = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        ir_we, pc_we, alu_src_b, mem_req, mem_we, rf_we, illegal, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic [3:0]  alu_op;
  logic [3:0]  retired;

  int total = 0;
  int bad   = 0;

  mc_ctrl_fsm #(.CNT_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b1; br_taken = 1'b0;
    nx();
    smp();
    chk("rst_state", state_o, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_retired", retired, 0);
    chk("rst_flags", {illegal, bus_err}, 0);
    nx();

    // add, zero wait
    rst_n = 1'b1; instr = ADD; mem_ready = 1'b1;
    smp(); chk("add_c1_state", state_o, 0); chk("add_c1_ir_we", ir_we, 1); chk("add_c1_mreq", mem_req, 1);
    chk("add_c1_rfpc", {rf_we, pc_we}, 0);
    nx(); smp(); chk("add_c2_state", state_o, 1); chk("add_c2_rfpc", {rf_we, pc_we}, 0);
    nx(); smp(); chk("add_c3_state", state_o, 2); chk("add_c3_src", {alu_src_b, alu_op}, 0);
    chk("add_c3_rfpc", {rf_we, pc_we}, 0);
    nx(); smp(); chk("add_c4_state", state_o, 4); chk("add_c4_rfpc", {rf_we, pc_we}, 2'b11);
    chk("add_c4_wb", wb_sel, 0);
    nx();

    // lw with two wait cycles in MEM
    instr = LW;
    smp(); chk("lw_fetch_state", state_o, 0); chk("add_retired", retired, 1);
    nx(); smp(); chk("lw_dec_imm", imm_sel, 1);
    nx(); smp(); chk("lw_exec", {state_o, imm_sel, alu_src_b, alu_op}, {3'd2, 3'd1, 1'b1, 4'd0});
    nx(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      smp();
      chk($sformatf("lw_mem%0d", i), {state_o, mem_req, mem_we, imm_sel, alu_src_b},
          {3'd3, 1'b1, 1'b0, 3'd1, 1'b1});
      nx();
    end
    smp(); chk("lw_wb", {state_o, wb_sel, rf_we}, {3'd4, 2'd1, 1'b1});
    nx();

    // beq taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      instr = BEQ; br_taken = t[0];
      smp(); chk("beq_fetch", state_o, 0);
      nx(); smp(); chk("beq_dec", {state_o, imm_sel}, {3'd1, 3'd3});
      nx(); smp();
      chk($sformatf("beq_exec_t%0d", t), {state_o, pc_we, pc_sel, imm_sel, rf_we},
          {3'd2, 1'b1, 2'(t), 3'd3, 1'b0});
      nx();
    end
    smp(); chk("beq_retired", {state_o, retired}, {3'd0, 4'd4});

    // illegal opcode traps and holds
    instr = BAD;
    nx(); smp(); chk("bad_dec", {state_o, illegal}, {3'd1, 1'b0});
    nx(); smp(); chk("bad_trap", {state_o, illegal}, {3'd5, 1'b1});
    for (int i = 0; i < 20; i++) begin
      nx(); smp();
      chk($sformatf("trap_hold%0d", i), {state_o, illegal, ir_we, pc_we, mem_req, mem_we, rf_we},
          {3'd5, 1'b1, 5'd0});
    end
    nx(); rst_n = 1'b0;
    smp(); chk("trap_rst_out", {ir_we, pc_we, mem_req, rf_we}, 0);
    nx(); smp(); chk("trap_rst_state", {state_o, illegal, retired}, 0);

    // fetch timeout
    nx(); rst_n = 1'b1; mem_ready = 1'b0; instr = ADD;
    for (int i = 0; i < 16; i++) begin
      smp(); chk($sformatf("to_wait%0d", i), {state_o, mem_req, bus_err}, {3'd0, 1'b1, 1'b0});
      nx();
    end
    smp(); chk("to_trap", {state_o, bus_err, mem_req}, {3'd5, 1'b1, 1'b0});

    // handshake on the last allowed cycle wins
    nx(); rst_n = 1'b0;
    nx(); rst_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      smp(); nx();
    end
    mem_ready = 1'b1;
    smp(); chk("hs16_ir_we", {state_o, ir_we, bus_err}, {3'd0, 1'b1, 1'b0});
    nx(); smp(); chk("hs16_decode", {state_o, bus_err}, {3'd1, 1'b0});

    // reset during store MEM phase
    nx(); rst_n = 1'b0;
    nx(); rst_n = 1'b1; instr = SW; mem_ready = 1'b1;
    smp(); chk("sw_fetch", {state_o, retired}, 0);
    nx(); nx(); smp(); chk("sw_exec_imm", {state_o, imm_sel}, {3'd2, 3'd2});
    nx(); mem_ready = 1'b0;
    smp(); chk("sw_mem", {state_o, mem_req, mem_we}, {3'd3, 1'b1, 1'b1});
    nx(); rst_n = 1'b0;
    smp(); chk("sw_rst_out", {mem_req, mem_we}, 0);
    nx(); smp(); chk("sw_after_rst", {state_o, mem_req, retired}, 0);
    nx(); rst_n = 1'b1; mem_ready = 1'b1; instr = ADD;
    smp(); chk("sw_refetch", {state_o, mem_req}, {3'd0, 1'b1});

    // retired counter wraps at 16
    for (int i = 0; i < 16; i++) begin
      repeat (4) nx();
      smp(); chk($sformatf("wrap%0d", i), {state_o, retired}, {3'd0, 4'((i + 1) % 16)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I single-memory-port core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and arbitrates the shared memory port between instruction fetch and data access.
- Drives the immediate-format select for the immediate generator, plus ALU operand/op selects, PC update, register-file write enable and writeback mux.
- Keeps a retired-instruction counter, a sticky illegal-instruction flag and a sticky bus-error flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).
- TIMEOUT, 16, consecutive cycles of mem_ready low in FETCH or MEM before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr  in  32  instruction register output; stable from the cycle after ir_we.
- mem_ready  in  1  memory handshake complete this cycle.
- br_taken  in  1  branch comparison result, valid in EXEC.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  2  0 = pc+4, 1 = pc+imm, 2 = ALU result.
- imm_sel  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  4  ALU operation code.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (stores only).
- rf_we  out  1  register-file write.
- wb_sel  out  2  0 ALU, 1 memory, 2 pc+4, 3 immediate.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.
- state_o  out  3  current state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n low at the clock edge):
  - state becomes FETCH; retired, illegal, bus_err and the wait counter clear.
  - While rst_n is low, all control outputs are 0.
  - Reset mid-transaction abandons it; mem_req is low in the cycle after the reset edge.
- Output timing:
  - Outputs are decoded combinationally from the state and the latched decode class.
  - ir_we, pc_we and pc_sel may also depend on mem_ready and br_taken in the same cycle.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ready=1: ir_we=1 that cycle, next state DECODE. Otherwise stay.
- DECODE (1 cycle): latch the class from instr[6:0]:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111.
  - Any other opcode: next state TRAP, illegal=1.
  - Otherwise: next state EXEC.
  - imm_sel is driven from DECODE through WB.
- EXEC (1 cycle), per class:
  - R: alu_src_b=0, alu_op={instr[30],funct3}, then WB.
  - I: alu_src_b=1, imm_sel=I, alu_op={instr[30]&(funct3==101),funct3}, then WB.
  - LOAD: imm_sel=I, alu_src_b=1, alu_op=0000, then MEM.
  - STORE: imm_sel=S, alu_src_b=1, alu_op=0000, then MEM.
  - BRANCH: imm_sel=B, alu_op=1000, pc_we=1, pc_sel=br_taken?1:0, retire, then FETCH.
  - JAL: imm_sel=J, then WB.
  - LUI: imm_sel=U, then WB.
- MEM:
  - mem_req=1; mem_we=1 for STORE only.
  - Hold the ALU address selects until mem_ready.
  - STORE with mem_ready: pc_we=1, pc_sel=0, retire, then FETCH.
  - LOAD with mem_ready: then WB.
- WB (1 cycle): rf_we=1, pc_we=1, retire, then FETCH.
  - wb_sel: R and I → 0, LOAD → 1, JAL → 2 with pc_sel=1, LUI → 3 with pc_sel=0.
- TRAP:
  - All enables 0; illegal or bus_err held.
  - Exit only via reset.
- Timeout:
  - The wait counter increments on each FETCH/MEM cycle with mem_ready=0 and clears on handshake or state change.
  - When it reaches TIMEOUT: next state TRAP, bus_err=1, mem_req low the following cycle.
  - If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT, the handshake wins.
- Retire: retired increments by 1 on each retire event and wraps from 2^CNT_W-1 to 0.
- Zero-wait latencies in cycles: R/I/JAL/LUI/STORE 4, LOAD 5, BRANCH 3.

Test Plan:
- Reset then `add` 0x002081B3 with mem_ready tied 1 → states 0,1,2,4; rf_we=1 and pc_we=1 in cycle 4 only; retired=1.
- `lw` 0x0000A103 with mem_ready low for 2 MEM cycles → MEM lasts 3 cycles with mem_req=1, mem_we=0, imm_sel=1; then WB with wb_sel=1.
- `beq`, br_taken=1 then repeated with br_taken=0 → EXEC asserts pc_we with pc_sel=1 and then 0, imm_sel=3; no rf_we; 3-cycle instructions.
- Opcode 0x0000007F → TRAP after DECODE; illegal=1 held for 20 cycles; no enables until rst_n low, after which state_o=0.
- TIMEOUT=16 with mem_ready held 0 in FETCH → TRAP entered after 16 wait cycles, bus_err=1; repeat with mem_ready=1 on cycle 16 → handshake, no trap.
- rst_n low during MEM of `sw` → mem_req=0 the next cycle, state FETCH, retired unchanged from 0; CNT_W=4 with 16 retirements → retired wraps to 0.
